dsk_stream_reader: RTL and testbench

DSK_STREAM_READER -- requirements
Module: dsk_stream_reader

---
 rtl/dsk_stream_reader_pkg.sv | 20 ++
 rtl/dsk_stream_reader_byte_fifo.sv | 73 +++++++
 rtl/dsk_stream_reader.sv | 116 +++++++++++
 tb/tb_dsk_stream_reader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dsk_stream_reader_pkg.sv
// ============================================================================
//  Module      : dsk_stream_reader_pkg
//  Description : Shared floppy constants: image address width, FIFO depth
//                default and the reader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsk_stream_reader_pkg;

    localparam int DSK_ADDR_W         = 22;
    localparam int FIFO_DEPTH_DEFAULT = 8;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dsk_stream_reader_byte_fifo.sv
// ============================================================================
//  Module      : byte_fifo
//  Description : Synchronous 8-bit FIFO accepting zero, one or two bytes per
//                edge (high byte of the word first), with flush and count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic [1:0]             i_push_cnt,
    input  logic [15:0]            i_push_data,
    input  logic                   i_pop,
    output logic [7:0]             o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem_q [DEPTH];
    logic [AW-1:0] r_wr_q;
    logic [AW-1:0] r_rd_q;
    logic [AW:0]   r_count_q;

    logic [AW-1:0] w_wr_d;
    logic [AW-1:0] w_rd_d;
    logic [AW:0]   w_count_d;
    logic [AW-1:0] w_wr_lo;
    logic          w_pop;

    always_comb begin
        w_pop     = i_pop && (r_count_q != '0);
        w_wr_lo   = r_wr_q + AW'(1);
        w_wr_d    = r_wr_q + AW'(i_push_cnt);
        w_rd_d    = w_pop ? (r_rd_q + AW'(1)) : r_rd_q;
        w_count_d = r_count_q + (AW+1)'(i_push_cnt) - (AW+1)'(w_pop);
        if (i_flush) begin
            w_wr_d    = '0;
            w_rd_d    = '0;
            w_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_q    <= '0;
            r_rd_q    <= '0;
            r_count_q <= '0;
        end else begin
            r_wr_q    <= w_wr_d;
            r_rd_q    <= w_rd_d;
            r_count_q <= w_count_d;
        end
    end

    // Storage is not reset; o_data is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush) begin
            if (i_push_cnt != 2'd0) r_mem_q[r_wr_q]  <= i_push_data[15:8];
            if (i_push_cnt == 2'd2) r_mem_q[w_wr_lo] <= i_push_data[7:0];
        end
    end

    assign o_data  = (r_count_q != '0) ? r_mem_q[r_rd_q] : 8'h00;
    assign o_count = r_count_q;

endmodule

`default_nettype wire

// File: rtl/dsk_stream_reader.sv
// ============================================================================
//  Module      : dsk_stream_reader
//  Description : Fetches a disk track word by word from the memory arbiter
//                and streams it out as bytes through a small FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsk_stream_reader
    import dsk_stream_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        clk8,
    input  logic        reset,
    input  logic        enable,
    input  logic        trackLoad,
    input  logic [21:0] trackStart,
    input  logic [15:0] trackLen,
    output logic [21:0] dskReadAddr,
    input  logic        dskReadAck,
    input  logic [15:0] memoryDataIn,
    output logic [7:0]  byteOut,
    output logic        byteValid,
    input  logic        byteReady,
    output logic        indexPulse
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DSK_ADDR_W-1:0] r_start_q;
    logic [15:0]           r_len_q;
    logic [15:0]           r_pos_q;
    logic                  r_index_q;

    logic [DSK_ADDR_W-1:0] w_start_d;
    logic [15:0]           w_len_d;
    logic [15:0]           w_pos_d;
    logic                  w_index_d;

    logic [1:0]            w_state;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_free;
    logic                  w_take;
    logic [16:0]           w_pos_next;
    logic                  w_wrap;
    logic [1:0]            w_push_cnt;
    logic                  w_pop;

    // Both bytes of a consumed word are pushed on the same edge; RUN
    // requires two free entries so the FIFO can never overflow.
    always_comb begin
        w_free = CW'(FIFO_DEPTH) - w_count;
        if (r_len_q == 16'd0)
            w_state = c_st_idle;
        else if (enable && (w_free >= CW'(2)))
            w_state = c_st_run;
        else
            w_state = c_st_hold;

        w_take     = dskReadAck && (w_state == c_st_run) && !trackLoad;
        w_pos_next = {1'b0, r_pos_q} + 17'd2;
        w_wrap     = w_pos_next >= {1'b0, r_len_q};
        w_push_cnt = 2'd0;
        if (w_take)
            w_push_cnt = (({1'b0, r_pos_q} + 17'd1) < {1'b0, r_len_q}) ? 2'd2 : 2'd1;
        w_pop = byteValid && byteReady;

        w_start_d = r_start_q;
        w_len_d   = r_len_q;
        w_pos_d   = r_pos_q;
        w_index_d = 1'b0;
        if (trackLoad) begin
            w_start_d = trackStart & ~22'h1;
            w_len_d   = trackLen;
            w_pos_d   = 16'd0;
        end else if (w_take) begin
            w_pos_d   = w_wrap ? 16'd0 : w_pos_next[15:0];
            w_index_d = w_wrap;
        end
    end

    always_ff @(posedge clk8) begin
        if (reset) begin
            r_start_q <= '0;
            r_len_q   <= '0;
            r_pos_q   <= '0;
            r_index_q <= 1'b0;
        end else begin
            r_start_q <= w_start_d;
            r_len_q   <= w_len_d;
            r_pos_q   <= w_pos_d;
            r_index_q <= w_index_d;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk8),
        .rst         (reset),
        .i_flush     (trackLoad),
        .i_push_cnt  (w_push_cnt),
        .i_push_data (memoryDataIn),
        .i_pop       (w_pop),
        .o_data      (byteOut),
        .o_count     (w_count)
    );

    assign dskReadAddr = r_start_q + DSK_ADDR_W'(r_pos_q);
    assign byteValid   = (w_count != '0);
    assign indexPulse  = r_index_q;

endmodule

`default_nettype wire

// File: tb/tb_dsk_stream_reader.sv
// ============================================================================
//  Module      : tb_dsk_stream_reader
//  Description : Directed self-checking bench for dsk_stream_reader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsk_stream_reader;

    logic        clk8 = 1'b0;
    logic        reset;
    logic        enable;
    logic        trackLoad;
    logic [21:0] trackStart;
    logic [15:0] trackLen;
    logic [21:0] dskReadAddr;
    logic        dskReadAck;
    logic [15:0] memoryDataIn;
    logic [7:0]  byteOut;
    logic        byteValid;
    logic        byteReady;
    logic        indexPulse;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_index  = 0;
    logic [7:0] got_q [$];

    dsk_stream_reader #(.FIFO_DEPTH(8)) dut (
        .clk8         (clk8),
        .reset        (reset),
        .enable       (enable),
        .trackLoad    (trackLoad),
        .trackStart   (trackStart),
        .trackLen     (trackLen),
        .dskReadAddr  (dskReadAddr),
        .dskReadAck   (dskReadAck),
        .memoryDataIn (memoryDataIn),
        .byteOut      (byteOut),
        .byteValid    (byteValid),
        .byteReady    (byteReady),
        .indexPulse   (indexPulse)
    );

    always #5 clk8 = ~clk8;

    // Record every accepted byte and every index pulse, sampled mid-cycle.
    always @(negedge clk8) begin
        if (byteValid && byteReady && !reset && !trackLoad) got_q.push_back(byteOut);
        if (indexPulse) n_index++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk8);
            #1;
        end
    endtask

    task automatic load(input logic [21:0] s, input logic [15:0] l);
        trackStart = s;
        trackLen   = l;
        trackLoad  = 1'b1;
        tick();
        trackLoad  = 1'b0;
    endtask

    task automatic ack(input logic [15:0] d);
        dskReadAck   = 1'b1;
        memoryDataIn = d;
        tick();
        dskReadAck   = 1'b0;
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] exp [$]);
        chk({tag, "_count"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_q.size(); i++)
            chk(tag, {24'h0, got_q[i]}, {24'h0, exp[i]});
    endtask

    initial begin
        logic [15:0] words [4];
        words = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
        reset = 1'b1; enable = 1'b0; trackLoad = 1'b0; trackStart = '0;
        trackLen = '0; dskReadAck = 1'b0; memoryDataIn = '0; byteReady = 1'b0;
        tick(3);
        chk("rst_addr",   dskReadAddr, 0);
        chk("rst_valid",  byteValid, 0);
        chk("rst_byte",   byteOut, 0);
        chk("rst_index",  indexPulse, 0);
        reset = 1'b0;
        tick();
        ack(16'h5555);
        chk("idle_ack_valid", byteValid, 0);
        chk("idle_ack_addr",  dskReadAddr, 0);

        // Basic streaming and wrap
        enable = 1'b1; byteReady = 1'b1;
        load(22'h01000, 16'd8);
        got_q.delete(); n_index = 0;
        for (int w = 0; w < 4; w++) begin
            tick(3);
            chk("seq_addr", dskReadAddr, 32'h01000 + 2 * w);
            ack(words[w]);
            if (w == 3) chk("seq_index", indexPulse, 1);
        end
        chk("seq_addr_wrap", dskReadAddr, 32'h01000);
        tick(6);
        chk_bytes("seq_byte", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
        chk("seq_index_cnt", n_index, 1);

        // Backpressure: FIFO fills, further acks ignored, drain is lossless
        byteReady = 1'b0;
        load(22'h02000, 16'd64);
        got_q.delete();
        for (int w = 0; w < 8; w++) ack(16'hA0A1 + 16'h0202 * w[15:0]);
        chk("full_valid", byteValid, 1);
        chk("full_head",  byteOut, 8'hA0);
        chk("full_addr",  dskReadAddr, 32'h02008);
        tick(2);
        chk("full_head_stable", byteOut, 8'hA0);
        byteReady = 1'b1;
        tick(10);
        chk_bytes("full_byte", '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7});
        chk("full_empty", byteValid, 0);
        enable = 1'b0;
        ack(16'h9999);
        chk("dis_addr",  dskReadAddr, 32'h02008);
        chk("dis_valid", byteValid, 0);
        enable = 1'b1;
        got_q.delete();
        ack(16'hB0B1);
        chk("resume_addr", dskReadAddr, 32'h0200A);
        tick(3);
        chk_bytes("resume_byte", '{8'hB0, 8'hB1});

        // Odd track length
        load(22'h03000, 16'd5);
        got_q.delete(); n_index = 0;
        ack(16'hAABB); tick();
        ack(16'hCCDD); tick();
        chk("odd_addr_last", dskReadAddr, 32'h03004);
        ack(16'hEEFF);
        chk("odd_index", indexPulse, 1);
        chk("odd_addr_wrap", dskReadAddr, 32'h03000);
        tick(4);
        chk_bytes("odd_byte", '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE});

        // trackLoad coincident with an ack
        byteReady = 1'b0;
        load(22'h04000, 16'd8);
        ack(16'h1234);
        chk("tl_pre_valid", byteValid, 1);
        trackStart = 22'h05000; trackLen = 16'd8; trackLoad = 1'b1;
        dskReadAck = 1'b1; memoryDataIn = 16'hDEAD;
        tick();
        trackLoad = 1'b0; dskReadAck = 1'b0;
        chk("tl_valid", byteValid, 0);
        chk("tl_addr",  dskReadAddr, 32'h05000);
        got_q.delete();
        byteReady = 1'b1;
        tick(3);
        chk("tl_no_bytes", got_q.size(), 0);

        // Reset mid-operation
        byteReady = 1'b0;
        load(22'h06000, 16'd8);
        ack(16'h0102); ack(16'h0304);
        byteReady = 1'b1; tick(); byteReady = 1'b0;
        chk("rm_head", byteOut, 8'h02);
        reset = 1'b1; dskReadAck = 1'b1; memoryDataIn = 16'h7777;
        tick();
        reset = 1'b0;
        chk("rm_valid", byteValid, 0);
        chk("rm_addr",  dskReadAddr, 0);
        ack(16'h4444); ack(16'h4545);
        chk("rm_idle_valid", byteValid, 0);
        chk("rm_idle_addr",  dskReadAddr, 0);

        // 22-bit address wrap, odd trackStart bit ignored
        byteReady = 1'b1;
        load(22'h01001, 16'd4);
        chk("odd_start", dskReadAddr, 32'h01000);
        load(22'h3FFFFE, 16'd4);
        chk("aw_addr0", dskReadAddr, 32'h3FFFFE);
        ack(16'h0000);
        chk("aw_addr1", dskReadAddr, 32'h000000);
        ack(16'h0000);
        chk("aw_addr2", dskReadAddr, 32'h3FFFFE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
